apb_uart_tx_bridge: RTL

APB_UART_TX_BRIDGE -- requirements
Module: apb_uart_tx_bridge

---
 rtl/uart_bridge_pkg.sv | 17 +
 rtl/uart_tx_frame.sv | 81 ++++++++
 rtl/apb_uart_tx_bridge.sv | 95 +++++++++
 3 files changed

// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg: register offsets, control/status bit positions and transmitter states
package uart_bridge_pkg;
  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL = 4'h8;
  localparam int CTRL_EN = 0;
  localparam int CTRL_PAR_EN = 1;
  localparam int CTRL_PAR_ODD = 2;
  localparam int CTRL_TWO_STOP = 3;
  localparam int CTRL_IRQ_EN = 4;
  localparam int CTRL_W = 5;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_ACTIVE = 2;
  localparam int ST_LEVEL = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
endpackage

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serialises one byte per frame with optional parity and one or two stop bits
module uart_tx_frame
  import uart_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       two_stop,
  output logic       serial,
  output logic       active,
  output logic       done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  tx_state_e state;
  logic [CW-1:0] cnt;
  logic [7:0] shreg;
  logic [2:0] idx;
  logic par_en, par_bit, stop2, tick;
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      state <= IDLE;
      cnt <= '0;
      shreg <= '0;
      idx <= '0;
      par_en <= 1'b0;
      par_bit <= 1'b0;
      stop2 <= 1'b0;
      serial <= 1'b1;
      active <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (start) begin
          state <= START;
          shreg <= data;
          par_en <= parity_en;
          par_bit <= ^data ^ parity_odd;
          stop2 <= two_stop;
          serial <= 1'b0;
          active <= 1'b1;
        end
        START: if (tick) begin
          state <= DATA;
          idx <= '0;
          serial <= shreg[0];
        end
        DATA: if (tick) begin
          shreg <= shreg >> 1;
          if (idx == 3'd7) begin
            state <= par_en ? PARITY : STOP;
            serial <= par_en ? par_bit : 1'b1;
            idx <= '0;
          end else begin
            idx <= idx + 1'b1;
            serial <= shreg[1];
          end
        end
        PARITY: if (tick) begin
          state <= STOP;
          serial <= 1'b1;
        end
        STOP: if (tick) begin
          if (stop2 && idx == 3'd0) idx <= 3'd1;
          else begin
            state <= IDLE;
            active <= 1'b0;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/apb_uart_tx_bridge.sv
// apb_uart_tx_bridge: APB slave filling a byte FIFO that drains into a UART transmitter
module apb_uart_tx_bridge
  import uart_bridge_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int CLKS_PER_BIT = 87
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr,
  output logic                o_tx_serial,
  output logic                o_tx_active,
  output logic                o_tx_done,
  output logic                o_irq
);
  localparam int LANES = DATA_W / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level;
  logic [CTRL_W-1:0] ctrl;
  logic [7:0] pos [LANES];
  logic [7:0] n_push;
  logic [15:0] status;
  logic access, is_tx, is_st, is_ctrl, tx_wr, stall, err, push, pop, empty, full;
  logic unused_addr;
  assign unused_addr = ^paddr[ADDR_W-1:4];
  assign access = psel & penable;
  assign is_tx = paddr[3:0] == OFF_TXDATA;
  assign is_st = paddr[3:0] == OFF_STATUS;
  assign is_ctrl = paddr[3:0] == OFF_CTRL;
  assign empty = level == '0;
  assign full = level == (AW+1)'(FIFO_DEPTH);
  assign pop = ctrl[CTRL_EN] & ~empty & ~o_tx_active;
  assign tx_wr = access & pwrite & is_tx & ctrl[CTRL_EN];
  assign stall = tx_wr & (16'(n_push) > 16'(FIFO_DEPTH) - 16'(level) + 16'(pop));
  assign push = tx_wr & ~stall;
  assign err = ~(is_tx | is_st | is_ctrl) | (pwrite & is_st) | (pwrite & is_tx & ~ctrl[CTRL_EN]);
  assign pready = ~stall;
  assign pslverr = access & err;
  assign prdata = (access & ~pwrite) ? (is_st ? DATA_W'(status) : is_ctrl ? DATA_W'(ctrl) : '0) : '0;
  always_comb begin
    status = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL] = full;
    status[ST_ACTIVE] = o_tx_active;
    status[ST_LEVEL +: 8] = 8'(level);
  end
  always_comb begin
    n_push = '0;
    for (int i = 0; i < LANES; i++) begin
      pos[i] = n_push;
      n_push = n_push + 8'(pstrb[i]);
    end
  end
  always_ff @(posedge pclk)
    for (int i = 0; i < LANES; i++)
      if (push && pstrb[i]) mem[wr_ptr + pos[i][AW-1:0]] <= pwdata[8*i +: 8];
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      ctrl <= '0;
      o_irq <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(n_push);
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (push ? (AW+1)'(n_push) : '0) - (AW+1)'(pop);
      if (access && pwrite && is_ctrl) ctrl <= pwdata[CTRL_W-1:0];
      o_irq <= ctrl[CTRL_IRQ_EN] & empty & ~o_tx_active;
    end
  uart_tx_frame #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_frame (
    .pclk(pclk),
    .presetn(presetn),
    .start(pop),
    .data(mem[rd_ptr]),
    .parity_en(ctrl[CTRL_PAR_EN]),
    .parity_odd(ctrl[CTRL_PAR_ODD]),
    .two_stop(ctrl[CTRL_TWO_STOP]),
    .serial(o_tx_serial),
    .active(o_tx_active),
    .done(o_tx_done)
  );
endmodule
